// File: rtl/i2c_slave_responder_if.sv
// ---------------------------------------------------------------------------
// i2c_slave_responder_if
// Bundles the board-facing I2C pins and the local register-pointer bus of
// the I2C target responder.
//   scl, sdaIn : raw SCL / SDA pin levels (into the target)
//   sdaOut     : 1 = pull SDA low (open-drain enable), 0 = release
//   regPtr     : current register pointer
//   wrData     : last written data byte
//   wrStrobe   : one-clk pulse, write wrData to regPtr
//   rdData     : register contents at regPtr (into the target)
//   rdStrobe   : one-clk pulse, rdData is being loaded for transmit
//   busy       : 1 from an address-matched START until STOP
// The slave modport is the target's view; master is the view of whatever
// drives the pins and serves the register file.
// ---------------------------------------------------------------------------
interface i2c_slave_responder_if;
    logic       scl;
    logic       sdaIn;
    logic       sdaOut;
    logic [7:0] regPtr;
    logic [7:0] wrData;
    logic       wrStrobe;
    logic [7:0] rdData;
    logic       rdStrobe;
    logic       busy;

    modport slave (
        input  scl, sdaIn, rdData,
        output sdaOut, regPtr, wrData, wrStrobe, rdStrobe, busy
    );

    modport master (
        output scl, sdaIn, rdData,
        input  sdaOut, regPtr, wrData, wrStrobe, rdStrobe, busy
    );
endinterface

// File: rtl/i2c_slave_responder.sv
// ---------------------------------------------------------------------------
// i2c_slave_responder
// I2C target with a register-pointer front end: the first written byte sets
// the pointer, further written bytes are strobed out as register writes, and
// reads fetch from the local register file with pointer auto-increment.
// Ports:
//   clk   : system clock, at least 10x the SCL frequency
//   reset : asynchronous active-low reset
//   bus   : i2c_slave_responder_if.slave (pins + register-pointer bus)
// Parameters:
//   ADDRESS  : 7-bit target address
//   SCL_SYNC : synchronizer depth on scl/sdaIn (at least 2)
// ---------------------------------------------------------------------------
module i2c_slave_responder #(
    parameter logic [6:0] ADDRESS  = 7'h77,
    parameter int         SCL_SYNC = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    i2c_slave_responder_if.slave  bus
);
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WR_PULSE,
        ST_WDATA_ACK,
        ST_RD_REQ,
        ST_RD_LOAD,
        ST_TX,
        ST_TX_LAST,
        ST_MACK,
        ST_MACK_OK,
        ST_IGNORE
    } state_t;

    // Pin synchronizers and edge-detect history. They reset to 1 (idle bus
    // level) so leaving reset never fabricates a START or an SCL edge.
    logic [SCL_SYNC-1:0] scl_sync_q, scl_sync_d;
    logic [SCL_SYNC-1:0] sda_sync_q, sda_sync_d;
    logic                scl_prev_q, scl_prev_d;
    logic                sda_prev_q, sda_prev_d;

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    // Only 7 bits are stored: on receive the 8th bit completes the byte
    // combinationally; on transmit the MSB goes straight to sda_out.
    logic [6:0]  shift_q, shift_d;
    logic        sda_out_q, sda_out_d;
    logic        busy_q, busy_d;
    logic        rw_q, rw_d;
    logic [7:0]  reg_ptr_q, reg_ptr_d;
    logic [7:0]  wr_data_q, wr_data_d;

    logic        scl_s, sda_s;
    logic        scl_rise, scl_fall;
    logic        start_det, stop_det;
    logic [7:0]  shift_in;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 7'd0;
            sda_out_q  <= 1'b0;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
            reg_ptr_q  <= 8'h00;
            wr_data_q  <= 8'h00;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            sda_out_q  <= sda_out_d;
            busy_q     <= busy_d;
            rw_q       <= rw_d;
            reg_ptr_q  <= reg_ptr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        scl_sync_d = {scl_sync_q[SCL_SYNC-2:0], bus.scl};
        sda_sync_d = {sda_sync_q[SCL_SYNC-2:0], bus.sdaIn};
        scl_s      = scl_sync_q[SCL_SYNC-1];
        sda_s      = sda_sync_q[SCL_SYNC-1];
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;

        scl_rise  = scl_s & ~scl_prev_q;
        scl_fall  = ~scl_s & scl_prev_q;
        // Qualified on the current SCL level only: if SCL rises in the same
        // clk as SDA moves, the bus condition takes precedence and the bit
        // is dropped.
        start_det = scl_s & sda_prev_q & ~sda_s;
        stop_det  = scl_s & ~sda_prev_q & sda_s;

        shift_in  = {shift_q, sda_s};

        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        sda_out_d = sda_out_q;
        busy_d    = busy_q;
        rw_d      = rw_q;
        reg_ptr_d = reg_ptr_q;
        wr_data_d = wr_data_q;

        if (stop_det) begin
            state_d   = ST_IDLE;
            sda_out_d = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = 3'd0;
        end else if (start_det) begin
            // busy is left alone until the new address byte is judged.
            state_d   = ST_ADDR;
            sda_out_d = 1'b0;
            bit_cnt_d = 3'd0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_IGNORE: begin
                    // Only a bus condition moves these states.
                end

                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = shift_in[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            // General call (address 0) is never claimed.
                            if ((shift_in[7:1] == ADDRESS) && (shift_in[7:1] != 7'd0)) begin
                                state_d = ST_ADDR_ACK;
                                busy_d  = 1'b1;
                                rw_d    = shift_in[0];
                            end else begin
                                state_d = ST_IGNORE;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end

                ST_ADDR_ACK: begin
                    // First fall starts the ACK, second fall ends it.
                    if (scl_fall) begin
                        if (!sda_out_q) begin
                            sda_out_d = 1'b1;
                        end else begin
                            bit_cnt_d = 3'd0;
                            if (rw_q) begin
                                // Hold SDA until the data MSB replaces it.
                                state_d = ST_RD_REQ;
                            end else begin
                                sda_out_d = 1'b0;
                                state_d   = ST_PTR;
                            end
                        end
                    end
                end

                ST_PTR: begin
                    if (scl_rise) begin
                        shift_d   = shift_in[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            reg_ptr_d = shift_in;
                            state_d   = ST_PTR_ACK;
                        end
                    end
                end

                ST_WDATA: begin
                    if (scl_rise) begin
                        shift_d   = shift_in[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            wr_data_d = shift_in;
                            state_d   = ST_WR_PULSE;
                        end
                    end
                end

                ST_WR_PULSE: begin
                    // wrStrobe is high in this state with the old pointer.
                    reg_ptr_d = reg_ptr_q + 8'd1;
                    state_d   = ST_WDATA_ACK;
                end

                ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!sda_out_q) begin
                            sda_out_d = 1'b1;
                        end else begin
                            sda_out_d = 1'b0;
                            bit_cnt_d = 3'd0;
                            state_d   = ST_WDATA;
                        end
                    end
                end

                ST_RD_REQ: begin
                    // rdStrobe is high here; rdData is sampled one clk later.
                    state_d = ST_RD_LOAD;
                end

                ST_RD_LOAD: begin
                    shift_d   = bus.rdData[6:0];
                    sda_out_d = ~bus.rdData[7];
                    reg_ptr_d = reg_ptr_q + 8'd1;
                    bit_cnt_d = 3'd0;
                    state_d   = ST_TX;
                end

                ST_TX: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = ST_TX_LAST;
                        end
                    end else if (scl_fall) begin
                        sda_out_d = ~shift_q[6];
                        shift_d   = {shift_q[5:0], 1'b0};
                    end
                end

                ST_TX_LAST: begin
                    if (scl_fall) begin
                        sda_out_d = 1'b0;
                        state_d   = ST_MACK;
                    end
                end

                ST_MACK: begin
                    if (scl_rise) begin
                        state_d = sda_s ? ST_IGNORE : ST_MACK_OK;
                    end
                end

                ST_MACK_OK: begin
                    if (scl_fall) begin
                        state_d = ST_RD_REQ;
                    end
                end

                default: begin
                    state_d   = ST_IDLE;
                    sda_out_d = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.wrStrobe = (state_q == ST_WR_PULSE);
        bus.rdStrobe = (state_q == ST_RD_REQ);
        bus.sdaOut   = sda_out_q;
        bus.regPtr   = reg_ptr_q;
        bus.wrData   = wr_data_q;
        bus.busy     = busy_q;
    end
endmodule

// File: tb/tb_i2c_slave_responder.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_responder
// Directed bench: drives the I2C pins as a master (open-drain wired-AND with
// the target), serves a small register file on rdData, and checks observed
// values against hand-computed expectations.
// Register file contents: mem[a] = a ^ 8'h3C, except mem[8'hD0] = 8'h55.
// ---------------------------------------------------------------------------
module tb_i2c_slave_responder;
    localparam int Q = 10;   // clk cycles per quarter SCL period

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic m_sda = 1'b1;
    logic sda_line;
    logic [7:0] mem [256];

    int n_cmp = 0;
    int n_err = 0;

    // Monitor counters (written only by the monitor process).
    int wr_cnt = 0;
    int rd_cnt = 0;
    int sda_cnt = 0;
    int busy_cnt = 0;
    logic [7:0] wr_ptr_seen = 8'h00;
    logic [7:0] wr_dat_seen = 8'h00;

    // Snapshots taken by the stimulus process.
    int wr0, rd0, sda0, busy0;
    logic a0, a1, a2, a3;
    logic [7:0] d0, d1, d2;

    i2c_slave_responder_if bus ();

    i2c_slave_responder #(
        .ADDRESS  (7'h77),
        .SCL_SYNC (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign sda_line    = m_sda & ~bus.sdaOut;
    assign bus.sdaIn   = sda_line;
    assign bus.rdData  = mem[bus.regPtr];

    always @(posedge clk) begin
        if (bus.wrStrobe) begin
            wr_cnt      <= wr_cnt + 1;
            wr_ptr_seen <= bus.regPtr;
            wr_dat_seen <= bus.wrData;
        end
        if (bus.rdStrobe) rd_cnt   <= rd_cnt + 1;
        if (bus.sdaOut)   sda_cnt  <= sda_cnt + 1;
        if (bus.busy)     busy_cnt <= busy_cnt + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic wait_q(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b0;      wait_q(Q);
        bus.scl = 1'b0;    wait_q(Q);
    endtask

    task automatic i2c_rep_start();
        m_sda = 1'b1;      wait_q(Q);
        bus.scl = 1'b1;    wait_q(Q);
        m_sda = 1'b0;      wait_q(Q);
        bus.scl = 1'b0;    wait_q(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0;      wait_q(Q);
        bus.scl = 1'b1;    wait_q(Q);
        m_sda = 1'b1;      wait_q(Q);
    endtask

    task automatic write_bit(input logic b);
        m_sda = b;         wait_q(Q);
        bus.scl = 1'b1;    wait_q(2 * Q);
        bus.scl = 1'b0;    wait_q(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1;      wait_q(Q);
        bus.scl = 1'b1;    wait_q(Q);
        @(negedge clk);
        b = sda_line;
        wait_q(Q);
        bus.scl = 1'b0;    wait_q(Q);
    endtask

    // ack = level seen on the ninth bit (0 = acknowledged).
    task automatic write_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(v[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            v[i] = b;
        end
        write_bit(nack);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
        mem[8'hD0] = 8'h55;
        bus.scl = 1'b1;

        // Reset state
        wait_q(4);
        @(negedge clk);
        chk("rst_sdaOut",   {7'd0, bus.sdaOut},   8'h00);
        chk("rst_regPtr",   bus.regPtr,           8'h00);
        chk("rst_wrData",   bus.wrData,           8'h00);
        chk("rst_busy",     {7'd0, bus.busy},     8'h00);
        chk("rst_wrStrobe", {7'd0, bus.wrStrobe}, 8'h00);
        chk("rst_rdStrobe", {7'd0, bus.rdStrobe}, 8'h00);
        reset = 1'b1;
        wait_q(Q);

        // Write sequence: START EE F4 2E STOP
        wr0 = wr_cnt;
        i2c_start();
        write_byte(8'hEE, a0);
        @(negedge clk);
        chk("wr_busy_mid", {7'd0, bus.busy}, 8'h01);
        write_byte(8'hF4, a1);
        write_byte(8'h2E, a2);
        i2c_stop();
        wait_q(Q);
        @(negedge clk);
        chk("wr_ack_addr", {7'd0, a0}, 8'h00);
        chk("wr_ack_ptr",  {7'd0, a1}, 8'h00);
        chk("wr_ack_data", {7'd0, a2}, 8'h00);
        chk("wr_strobes",  8'(wr_cnt - wr0), 8'h01);
        chk("wr_ptr_seen", wr_ptr_seen, 8'hF4);
        chk("wr_dat_seen", wr_dat_seen, 8'h2E);
        chk("wr_regPtr",   bus.regPtr,  8'hF5);
        chk("wr_busy_end", {7'd0, bus.busy}, 8'h00);

        // BMP180 ID read: START EE D0 Sr EF read(NACK) STOP
        rd0 = rd_cnt;
        i2c_start();
        write_byte(8'hEE, a0);
        write_byte(8'hD0, a1);
        i2c_rep_start();
        write_byte(8'hEF, a2);
        read_byte(1'b1, d0);
        i2c_stop();
        wait_q(Q);
        @(negedge clk);
        chk("id_ack_addr", {7'd0, a0}, 8'h00);
        chk("id_ack_ptr",  {7'd0, a1}, 8'h00);
        chk("id_ack_rd",   {7'd0, a2}, 8'h00);
        chk("id_data",     d0, 8'h55);
        chk("id_rdstrobe", 8'(rd_cnt - rd0), 8'h01);
        chk("id_regPtr",   bus.regPtr, 8'hD1);

        // Address mismatch: START EC 00 STOP
        wr0 = wr_cnt; rd0 = rd_cnt; sda0 = sda_cnt; busy0 = busy_cnt;
        i2c_start();
        write_byte(8'hEC, a0);
        write_byte(8'h00, a1);
        i2c_stop();
        wait_q(Q);
        @(negedge clk);
        chk("mm_nack_addr", {7'd0, a0}, 8'h01);
        chk("mm_nack_data", {7'd0, a1}, 8'h01);
        chk("mm_sda_cycles", 8'(sda_cnt - sda0), 8'h00);
        chk("mm_wrstrobe",   8'(wr_cnt - wr0),   8'h00);
        chk("mm_rdstrobe",   8'(rd_cnt - rd0),   8'h00);
        chk("mm_busy_cycles", 8'(busy_cnt - busy0), 8'h00);

        // Burst read with pointer wrap from FE
        rd0 = rd_cnt;
        i2c_start();
        write_byte(8'hEE, a0);
        write_byte(8'hFE, a1);
        i2c_rep_start();
        write_byte(8'hEF, a2);
        read_byte(1'b0, d0);
        read_byte(1'b0, d1);
        read_byte(1'b1, d2);
        i2c_stop();
        wait_q(Q);
        @(negedge clk);
        chk("burst_ack_rd", {7'd0, a2}, 8'h00);
        chk("burst_d0",     d0, 8'hC2);
        chk("burst_d1",     d1, 8'hC3);
        chk("burst_d2",     d2, 8'h3C);
        chk("burst_rdstrobes", 8'(rd_cnt - rd0), 8'h03);
        chk("burst_regPtr", bus.regPtr, 8'h01);

        // STOP after 4 data bits
        wr0 = wr_cnt;
        i2c_start();
        write_byte(8'hEE, a0);
        write_byte(8'h10, a1);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        i2c_stop();
        wait_q(Q);
        @(negedge clk);
        chk("abort_wrstrobe", 8'(wr_cnt - wr0), 8'h00);
        chk("abort_regPtr",   bus.regPtr, 8'h10);
        chk("abort_busy",     {7'd0, bus.busy}, 8'h00);
        i2c_start();
        write_byte(8'hEE, a3);
        i2c_stop();
        wait_q(Q);
        chk("abort_reack", {7'd0, a3}, 8'h00);

        // Reset during TX while sdaOut=1 (mem[20] = 1C, MSB 0)
        i2c_start();
        write_byte(8'hEE, a0);
        write_byte(8'h20, a1);
        i2c_rep_start();
        write_byte(8'hEF, a2);
        @(negedge clk);
        chk("txrst_sda_before", {7'd0, bus.sdaOut}, 8'h01);
        reset = 1'b0;
        #1;
        chk("txrst_sda_async",  {7'd0, bus.sdaOut}, 8'h00);
        chk("txrst_regPtr",     bus.regPtr, 8'h00);
        chk("txrst_busy",       {7'd0, bus.busy}, 8'h00);
        wait_q(3);
        m_sda = 1'b1;
        bus.scl = 1'b1;
        reset = 1'b1;
        wait_q(2 * Q);
        wr0 = wr_cnt;
        i2c_start();
        write_byte(8'hEE, a0);
        write_byte(8'h33, a1);
        write_byte(8'h44, a2);
        i2c_stop();
        wait_q(Q);
        @(negedge clk);
        chk("post_ack_addr", {7'd0, a0}, 8'h00);
        chk("post_ack_data", {7'd0, a2}, 8'h00);
        chk("post_wrstrobe", 8'(wr_cnt - wr0), 8'h01);
        chk("post_wr_ptr",   wr_ptr_seen, 8'h33);
        chk("post_wr_dat",   wr_dat_seen, 8'h44);
        chk("post_regPtr",   bus.regPtr,  8'h34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
